// File: rtl/frequency_window_controller.sv
// Sequences the two-tone analyzer through fixed windows and decides one symbol per window.
// Optional overrun/drop mode: define FREQUENCY_WINDOW_CTRL_OVERRUN_DROP_EN.
module frequency_window_controller #(
  parameter int WINDOW_TICKS = 50000,
  parameter int MIN_TOTAL    = 25000,
  parameter int MARGIN_SHIFT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic        an_enable,
  output logic        an_clear,
  input  logic [31:0] f1_value,
  input  logic [31:0] f2_value,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic        sym_bit,
  output logic [1:0]  sym_flags,
  output logic        busy,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, LATCH, DECIDE, PRESENT} state_t;

  localparam logic [23:0] LAST_TICK = 24'(WINDOW_TICKS - 1);

  state_t      state;
  logic [23:0] count;
  logic [31:0] r1;
  logic [31:0] r2;

  logic [32:0] sum;
  logic [31:0] diff;
  logic        no_signal;
  logic        ambiguous;
  logic        tone2;
  logic        handshake;

  // Sum is kept at 33 bits so two large totals never wrap into a false no-signal.
  always_comb begin
    sum       = {1'b0, r1} + {1'b0, r2};
    diff      = (r1 >= r2) ? (r1 - r2) : (r2 - r1);
    no_signal = sum < 33'(MIN_TOTAL);
    ambiguous = !no_signal && ({1'b0, diff} < (sum >> MARGIN_SHIFT));
    tone2     = r2 > r1;
    handshake = sym_valid && sym_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      r1        <= '0;
      r2        <= '0;
      an_enable <= 1'b0;
      an_clear  <= 1'b0;
      sym_valid <= 1'b0;
      sym_bit   <= 1'b0;
      sym_flags <= 2'b00;
      busy      <= 1'b0;
`ifdef FREQUENCY_WINDOW_CTRL_OVERRUN_DROP_EN
      drop_count <= '0;
`endif
    end else begin
      an_clear <= 1'b0;
      // A result may be accepted in any state once windows overlap presentation.
      if (handshake) sym_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state     <= CLEAR;
            an_clear  <= 1'b1;
            an_enable <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          state <= MEASURE;
          count <= '0;
        end
        MEASURE: begin
          if (count == LAST_TICK) begin
            state     <= LATCH;
            an_enable <= 1'b0;
          end else begin
            count <= count + 24'd1;
          end
        end
        LATCH: begin
          r1    <= f1_value;
          r2    <= f2_value;
          state <= DECIDE;
        end
        DECIDE: begin
          sym_bit   <= tone2;
          sym_flags <= {ambiguous, no_signal};
          sym_valid <= 1'b1;
          state     <= PRESENT;
`ifdef FREQUENCY_WINDOW_CTRL_OVERRUN_DROP_EN
          if (sym_valid && !sym_ready && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
`endif
        end
        PRESENT: begin
`ifdef FREQUENCY_WINDOW_CTRL_OVERRUN_DROP_EN
          if (run) begin
            state     <= CLEAR;
            an_clear  <= 1'b1;
            an_enable <= 1'b1;
          end else if (handshake) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          if (handshake) begin
            if (run) begin
              state     <= CLEAR;
              an_clear  <= 1'b1;
              an_enable <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
`endif
        end
        default: begin
          state     <= IDLE;
          an_enable <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifndef FREQUENCY_WINDOW_CTRL_OVERRUN_DROP_EN
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_frequency_window_controller.sv
// Bench for frequency_window_controller: vector table, random windows against a model, corner sequences.
// Expectations for the overrun mode follow FREQUENCY_WINDOW_CTRL_OVERRUN_DROP_EN.
module tb_frequency_window_controller;
  localparam int W   = 100;
  localparam int MIN = 25000;
  localparam int SH  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        sym_ready = 1'b0;
  logic [31:0] f1_value = '0;
  logic [31:0] f2_value = '0;
  logic        an_enable;
  logic        an_clear;
  logic        sym_valid;
  logic        sym_bit;
  logic [1:0]  sym_flags;
  logic        busy;
  logic [15:0] drop_count;

  int total = 0;
  int bad = 0;

  frequency_window_controller #(
    .WINDOW_TICKS(W),
    .MIN_TOTAL(MIN),
    .MARGIN_SHIFT(SH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .an_enable(an_enable),
    .an_clear(an_clear),
    .f1_value(f1_value),
    .f2_value(f2_value),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym_bit(sym_bit),
    .sym_flags(sym_flags),
    .busy(busy),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] f1;
    logic [31:0] f2;
    logic        exp_bit;
    logic [1:0]  exp_flags;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic check_output(input string name, input logic got_bit, input logic [1:0] got_flags,
                              input logic exp_bit, input logic [1:0] exp_flags);
    check({name, "_bit"}, {31'd0, got_bit}, {31'd0, exp_bit});
    check({name, "_flags"}, {30'd0, got_flags}, {30'd0, exp_flags});
  endtask

  // Decision rules stated directly in integer arithmetic.
  function automatic void model(input logic [31:0] f1, input logic [31:0] f2,
                                output logic b, output logic [1:0] fl);
    longint a;
    longint c;
    longint s;
    longint d;
    logic ns;
    logic amb;
    a = {32'd0, f1};
    c = {32'd0, f2};
    s = a + c;
    d = (a > c) ? a - c : c - a;
    ns = s < MIN;
    amb = !ns && (d < s / (64'sd1 << SH));
    b = c > a;
    fl = {amb, ns};
  endfunction

  task automatic wait_valid(input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (sym_valid) seen = 1;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] f1, input logic [31:0] f2, input bit early_ready,
                                output logic got_bit, output logic [1:0] got_flags);
    int  cycles = 0;
    int  en_cycles = 0;
    int  clr_cycles = 0;
    bit  seen = 0;
    f1_value = f1;
    f2_value = f2;
    sym_ready = early_ready;
    run = 1'b1;
    for (int i = 0; i < W + 20 && !seen; i++) begin
      tick();
      run = 1'b0;
      cycles++;
      if (an_enable) en_cycles++;
      if (an_clear) clr_cycles++;
      if (sym_valid) seen = 1;
    end
    check("valid_seen", {31'd0, seen}, 32'd1);
    check("latency", cycles, W + 4);
    check("enable_cycles", en_cycles, W + 1);
    check("clear_pulses", clr_cycles, 1);
    got_bit = sym_bit;
    got_flags = sym_flags;
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    check("valid_after_hs", {31'd0, sym_valid}, 32'd0);
    check("busy_after_hs", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_enable"}, {31'd0, an_enable}, 32'd0);
    check({name, "_clear"}, {31'd0, an_clear}, 32'd0);
    check({name, "_valid"}, {31'd0, sym_valid}, 32'd0);
    check({name, "_bit"}, {31'd0, sym_bit}, 32'd0);
    check({name, "_flags"}, {30'd0, sym_flags}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_drops"}, {16'd0, drop_count}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[12];
    logic        gb;
    logic [1:0]  gf;
    logic        eb;
    logic [1:0]  ef;
    logic [31:0] rf1;
    logic [31:0] rf2;
    bit          seen;
    int          lost;
    int          changed;
    int          clears;

    vecs[0]  = '{32'd80000, 32'd10000, 1'b0, 2'b00};
    vecs[1]  = '{32'd10, 32'd90000, 1'b1, 2'b00};
    vecs[2]  = '{32'd40000, 32'd40000, 1'b0, 2'b10};
    vecs[3]  = '{32'd100, 32'd200, 1'b1, 2'b01};
    vecs[4]  = '{32'd0, 32'd0, 1'b0, 2'b01};
    vecs[5]  = '{32'hFFFFFFFF, 32'd1, 1'b0, 2'b00};
    vecs[6]  = '{32'd12500, 32'd12499, 1'b0, 2'b01};
    vecs[7]  = '{32'd12500, 32'd12500, 1'b0, 2'b10};
    vecs[8]  = '{32'd25000, 32'd15000, 1'b0, 2'b00};
    vecs[9]  = '{32'd14999, 32'd25001, 1'b1, 2'b00};
    vecs[10] = '{32'd24999, 32'd15001, 1'b0, 2'b10};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2'b10};

    reset = 1'b1;
    tick(); tick(); tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].f1, vecs[i].f2, i[0], gb, gf);
      check_output($sformatf("vec%0d", i), gb, gf, vecs[i].exp_bit, vecs[i].exp_flags);
    end

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0: begin rf1 = $urandom_range(0, 20000); rf2 = $urandom_range(0, 20000); end
        1: begin rf1 = $urandom_range(0, 100000); rf2 = $urandom_range(0, 100000); end
        2: begin rf1 = $urandom_range(10000, 60000); rf2 = rf1 + $urandom_range(0, 30000); end
        default: begin rf1 = $urandom; rf2 = $urandom; end
      endcase
      model(rf1, rf2, eb, ef);
      apply_stimulus(rf1, rf2, $urandom_range(0, 1) == 1, gb, gf);
      check_output($sformatf("rand%0d", i), gb, gf, eb, ef);
    end

    // Reset in the middle of a measurement window, then a full-length window.
    f1_value = 32'd80000;
    f2_value = 32'd10000;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("midwin_enable", {31'd0, an_enable}, 32'd1);
    reset = 1'b1;
    tick();
    check_reset_state("midreset");
    reset = 1'b0;
    tick();
    apply_stimulus(32'd80000, 32'd10000, 1'b0, gb, gf);
    check_output("after_reset", gb, gf, 1'b0, 2'b00);

    // Backpressure with run held high.
    f1_value = 32'd80000;
    f2_value = 32'd10000;
    sym_ready = 1'b0;
    run = 1'b1;
    wait_valid(W + 20, seen);
    check("bp_valid_seen", {31'd0, seen}, 32'd1);
    lost = 0;
    changed = 0;
    clears = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!sym_valid) lost++;
      if (sym_bit !== 1'b0 || sym_flags !== 2'b00) changed++;
      if (an_clear) clears++;
    end
    check("bp_valid_lost", lost, 0);
    check("bp_data_changed", changed, 0);
    f1_value = 32'd10;
    f2_value = 32'd90000;
`ifdef FREQUENCY_WINDOW_CTRL_OVERRUN_DROP_EN
    check("bp_parallel_clear", clears, 1);
    run = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 20 && !seen; i++) begin
      tick();
      if (drop_count != 16'd0) seen = 1;
    end
    check("ovr_drop_seen", {31'd0, seen}, 32'd1);
    check("ovr_drop_count", {16'd0, drop_count}, 32'd1);
    check("ovr_valid", {31'd0, sym_valid}, 32'd1);
    check_output("ovr_result", sym_bit, sym_flags, 1'b1, 2'b00);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    check("ovr_valid_after_hs", {31'd0, sym_valid}, 32'd0);
    check("ovr_busy_after_hs", {31'd0, busy}, 32'd0);
`else
    check("bp_clear_stalled", clears, 0);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    run = 1'b0;
    check("bp_clear_after_hs", {31'd0, an_clear}, 32'd1);
    check("bp_valid_after_hs", {31'd0, sym_valid}, 32'd0);
    wait_valid(W + 20, seen);
    check("bp_next_seen", {31'd0, seen}, 32'd1);
    check_output("bp_next", sym_bit, sym_flags, 1'b1, 2'b00);
    check("bp_drops", {16'd0, drop_count}, 32'd0);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    check("bp_busy_end", {31'd0, busy}, 32'd0);
`endif

    // Run dropped mid-measurement: the window still completes and delivers.
    f1_value = 32'd100;
    f2_value = 32'd200;
    run = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    run = 1'b0;
    check("rundrop_busy", {31'd0, busy}, 32'd1);
    wait_valid(W + 20, seen);
    check("rundrop_seen", {31'd0, seen}, 32'd1);
    check_output("rundrop", sym_bit, sym_flags, 1'b1, 2'b01);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    tick();
    tick();
    check("rundrop_idle_busy", {31'd0, busy}, 32'd0);
    check("rundrop_idle_enable", {31'd0, an_enable}, 32'd0);
    check("rundrop_idle_valid", {31'd0, sym_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frequency_window_controller.md
# frequency_window_controller

Sequences the two-tone frequency analyzer through fixed measurement windows and turns each window's f1/f2 tick totals into one decided symbol. It drives the analyzer's `enable` and `clear`, latches both 32-bit totals at the window end, and classifies the window as tone 1, tone 2 or no-signal. Each result is presented on a valid/ready output for the downstream symbol/frame logic in the capture path.

## Interface
- `WINDOW_TICKS`, 50000: clock cycles per measurement window (1 ms at 50 MHz); legal range 2..2^24-1.
- `MIN_TOTAL`, 25000: minimum f1+f2 tick sum for a window to count as carrying signal.
- `MARGIN_SHIFT`, 2: the winning total must exceed the loser by at least `(f1+f2) >> MARGIN_SHIFT`; otherwise the symbol is ambiguous.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; while high, windows repeat back-to-back.
- `an_enable`  out  1  to analyzer `enable`.
- `an_clear`  out  1  to analyzer `clear`; one-cycle pulse.
- `f1_value`  in  32  analyzer tone-1 tick total.
- `f2_value`  in  32  analyzer tone-2 tick total.
- `sym_valid`  out  1  result available.
- `sym_ready`  in  1  downstream accepts the result.
- `sym_bit`  out  1  1 means tone 2 dominant, 0 means tone 1 dominant.
- `sym_flags`  out  2  [0] no_signal, [1] ambiguous.
- `busy`  out  1  high in any state other than IDLE.
- `drop_count`  out  16  count of results lost to overrun (0 if the feature is off).

## Operation
- FSM states: IDLE, CLEAR, MEASURE, LATCH, DECIDE, PRESENT.
- IDLE: all outputs idle. When `run`=1, go to CLEAR.
- CLEAR: `an_clear`=1 and `an_enable`=1 for exactly one cycle; the window counter loads 0. Next state is MEASURE.
- MEASURE: `an_enable`=1; the counter increments each cycle. When the counter reaches `WINDOW_TICKS-1`, go to LATCH.
- LATCH: `an_enable`=0; capture `f1_value` and `f2_value` into registers `r1` and `r2`.
- DECIDE:
  - `sum` = `r1` + `r2`, computed at 33 bits with no wrap.
  - `no_signal` = `sum` < `MIN_TOTAL`.
  - `diff` = |`r1` − `r2`|.
  - `ambiguous` = !`no_signal` && `diff` < (`sum` >> `MARGIN_SHIFT`).
  - `sym_bit` = `r2` > `r1`. On a tie, `sym_bit`=0.
  - Register the results, then go to PRESENT.
- PRESENT: `sym_valid`=1, and the outputs hold stable until `sym_valid`&&`sym_ready`. On that handshake, go to CLEAR if `run`=1, else IDLE.
- `run` dropping mid-window does not abort the window. The current window completes and its result is presented.
- `reset` in any state: next cycle is IDLE, `an_enable`=0, `an_clear`=0, `sym_valid`=0, `sym_bit`=0, `sym_flags`=0, `busy`=0, `drop_count`=0, counter=0.

## Timing
- `run` rises in cycle 0 → CLEAR in cycle 1 → MEASURE in cycles 2..`WINDOW_TICKS`+1 → LATCH → DECIDE → `sym_valid` high at cycle `WINDOW_TICKS`+4.
- Window-end to valid latency is 3 cycles.
- With `sym_ready` held at 1, the period per symbol is `WINDOW_TICKS`+4 cycles.
- `sym_ready` may be high before `sym_valid`; the handshake completes in the first cycle `sym_valid` is high.
- Output registers are stable between valid assertion and handshake.

## Configuration
- Macro: `FREQUENCY_WINDOW_CTRL_OVERRUN_DROP_EN`.
- Undefined (default): PRESENT blocks. No new window starts until the handshake, so measurement stalls under backpressure. `drop_count` is tied to 0.
- Defined:
  - After PRESENT has been entered, a new CLEAR/MEASURE window runs in parallel if `run`=1.
  - If the next DECIDE finishes while `sym_valid` is still high, the pending result is overwritten by the new one and `drop_count` increments, saturating at 0xFFFF.
  - A handshake in the same cycle as the overwrite counts as delivered, not dropped.

## Test plan
- **Basic decision.** `WINDOW_TICKS`=100, `run` pulse. Stub totals f1=80000, f2=10000 → `sym_bit`=0, flags=00, `sym_valid` at cycle 104, then IDLE.
- **Tone 2 and tie.** f1=10, f2=90000 → `sym_bit`=1, flags=00. f1=f2=40000 → `sym_bit`=0, flags=10 (ambiguous).
- **No signal.** f1=100, f2=200 with `MIN_TOTAL`=25000 → flags=01, `sym_bit`=1.
- **Backpressure.** `sym_ready`=0 for 50 cycles with `run`=1 → valid and data stable for all 50 cycles, no `an_clear` pulse until the handshake. With the macro defined, a second window completes and `drop_count`=1.
- **Reset mid-window.** `reset` at cycle 40 of MEASURE → next cycle all outputs are at their reset values. After `run` is reasserted, the next window is a full `WINDOW_TICKS` long.
- **Run drop.** `run` deasserted mid-MEASURE → the window completes, one symbol is delivered, then IDLE with `busy`=0.
